// File: rtl/cpu6_mux_uart.sv
// CPU6 MUX channel 0: memory-mapped 8N1 serial port with a status register at
// BASE_ADDRESS and a data register at BASE_ADDRESS+1.
module cpu6_mux_uart #(
  parameter logic [15:0] BASE_ADDRESS = 16'hF200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  writeData,
  output logic [7:0]  readData,
  input  logic        writeEnable,
  input  logic        readEnable,
  output logic        selected,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] DATA_ADDRESS = BASE_ADDRESS + 16'd1;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  txState_t    txState_r;
  logic [15:0] txCnt_r;
  logic [2:0]  txBitIdx_r;
  logic [7:0]  txShift_r;
  logic        txd_r;
  logic [7:0]  holdReg_r;
  logic        holdFull_r;

  rxState_t    rxState_r;
  logic [15:0] rxCnt_r;
  logic [2:0]  rxBitIdx_r;
  logic [7:0]  rxShift_r;
  logic [7:0]  rxBuf_r;
  logic        rxReady_r;
  logic        overrun_r;
  logic        framingErr_r;
  logic        rxMeta_r;
  logic        rxs_r;

  logic statusSel_s;
  logic dataSel_s;
  logic statusWrite_s;
  logic dataWrite_s;
  logic dataRead_s;
  logic txTake_s;
  logic rxDeliver_s;

  assign statusSel_s   = (addressBus == BASE_ADDRESS);
  assign dataSel_s     = (addressBus == DATA_ADDRESS);
  assign selected      = statusSel_s | dataSel_s;
  assign statusWrite_s = writeEnable & statusSel_s;
  assign dataWrite_s   = writeEnable & dataSel_s;
  // A simultaneous write wins, so the read then has no side effect.
  assign dataRead_s    = readEnable & ~writeEnable & dataSel_s;
  assign txTake_s      = (txState_r == TX_IDLE) & holdFull_r;
  assign rxDeliver_s   = (rxState_r == RX_STOP) & (rxCnt_r == BIT_LAST);
  assign txd           = txd_r;

  // Register read mux, valid in the same cycle the address is presented
  always_comb begin
    readData = 8'h00;
    if (statusSel_s) begin
      readData = {4'b0000, framingErr_r, overrun_r, ~holdFull_r, rxReady_r};
    end else if (dataSel_s) begin
      readData = rxBuf_r;
    end else begin
      readData = 8'h00;
    end
  end

  // Transmit holding register; a write on the take edge refills it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      holdReg_r  <= 8'h00;
      holdFull_r <= 1'b0;
    end else if (dataWrite_s && (!holdFull_r || txTake_s)) begin
      holdReg_r  <= writeData;
      holdFull_r <= 1'b1;
    end else if (txTake_s) begin
      holdFull_r <= 1'b0;
    end
  end

  // Transmit FSM; txd is registered from the state, lagging it by one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txState_r  <= TX_IDLE;
      txCnt_r    <= 16'd0;
      txBitIdx_r <= 3'd0;
      txShift_r  <= 8'h00;
      txd_r      <= 1'b1;
    end else begin
      case (txState_r)
        TX_IDLE: begin
          txd_r      <= 1'b1;
          txCnt_r    <= 16'd0;
          txBitIdx_r <= 3'd0;
          if (holdFull_r) begin
            txShift_r <= holdReg_r;
            txState_r <= TX_START;
          end
        end
        TX_START: begin
          txd_r <= 1'b0;
          if (txCnt_r == BIT_LAST) begin
            txCnt_r   <= 16'd0;
            txState_r <= TX_DATA;
          end else begin
            txCnt_r <= txCnt_r + 16'd1;
          end
        end
        TX_DATA: begin
          txd_r <= txShift_r[0];
          if (txCnt_r == BIT_LAST) begin
            txCnt_r    <= 16'd0;
            txShift_r  <= {1'b0, txShift_r[7:1]};
            txBitIdx_r <= txBitIdx_r + 3'd1;
            if (txBitIdx_r == 3'd7) begin
              txState_r <= TX_STOP;
            end
          end else begin
            txCnt_r <= txCnt_r + 16'd1;
          end
        end
        TX_STOP: begin
          txd_r <= 1'b1;
          if (txCnt_r == BIT_LAST) begin
            txCnt_r   <= 16'd0;
            txState_r <= TX_IDLE;
          end else begin
            txCnt_r <= txCnt_r + 16'd1;
          end
        end
        default: begin
          txd_r     <= 1'b1;
          txCnt_r   <= 16'd0;
          txState_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxMeta_r <= 1'b1;
      rxs_r    <= 1'b1;
    end else begin
      rxMeta_r <= rxd;
      rxs_r    <= rxMeta_r;
    end
  end

  // Receive FSM plus the CPU-visible receive flags and buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxState_r    <= RX_IDLE;
      rxCnt_r      <= 16'd0;
      rxBitIdx_r   <= 3'd0;
      rxShift_r    <= 8'h00;
      rxBuf_r      <= 8'h00;
      rxReady_r    <= 1'b0;
      overrun_r    <= 1'b0;
      framingErr_r <= 1'b0;
    end else begin
      case (rxState_r)
        RX_IDLE: begin
          rxCnt_r    <= 16'd0;
          rxBitIdx_r <= 3'd0;
          if (!rxs_r) begin
            rxState_r <= RX_START;
          end
        end
        RX_START: begin
          // Re-check mid start bit; a high level here was only a glitch
          if (rxCnt_r == HALF_LAST) begin
            rxCnt_r   <= 16'd0;
            rxState_r <= rxs_r ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_r <= rxCnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt_r == BIT_LAST) begin
            rxCnt_r    <= 16'd0;
            rxShift_r  <= {rxs_r, rxShift_r[7:1]};
            rxBitIdx_r <= rxBitIdx_r + 3'd1;
            if (rxBitIdx_r == 3'd7) begin
              rxState_r <= RX_STOP;
            end
          end else begin
            rxCnt_r <= rxCnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (rxCnt_r == BIT_LAST) begin
            rxCnt_r   <= 16'd0;
            rxState_r <= RX_IDLE;
          end else begin
            rxCnt_r <= rxCnt_r + 16'd1;
          end
        end
        default: begin
          rxCnt_r   <= 16'd0;
          rxState_r <= RX_IDLE;
        end
      endcase

      if (rxDeliver_s && (!rxReady_r || dataRead_s)) begin
        rxBuf_r   <= rxShift_r;
        rxReady_r <= 1'b1;
      end else if (dataRead_s) begin
        rxReady_r <= 1'b0;
      end

      // Setting a flag takes priority over a same-edge clear
      if (rxDeliver_s && rxReady_r && !dataRead_s) begin
        overrun_r <= 1'b1;
      end else if (statusWrite_s && writeData[2]) begin
        overrun_r <= 1'b0;
      end

      if (rxDeliver_s && !rxs_r) begin
        framingErr_r <= 1'b1;
      end else if (statusWrite_s && writeData[3]) begin
        framingErr_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu6_mux_uart.sv
// Scoreboarded bench for cpu6_mux_uart: a UART-level TX decoder and a read
// monitor check DUT outputs against expectations pushed by the stimulus.
module tb_cpu6_mux_uart;
  localparam int CPB = 4;
  localparam logic [15:0] ST = 16'hF200;
  localparam logic [15:0] DT = 16'hF201;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addressBus = 16'h0000;
  logic [7:0]  writeData = 8'h00;
  logic [7:0]  readData;
  logic        writeEnable = 1'b0;
  logic        readEnable = 1'b0;
  logic        selected;
  logic        txd;
  logic        rxd = 1'b1;

  cpu6_mux_uart #(.BASE_ADDRESS(16'hF200), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .writeData(writeData),
    .readData(readData), .writeEnable(writeEnable), .readEnable(readEnable),
    .selected(selected), .txd(txd), .rxd(rxd));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] txExpQ[$];
  int         txStartQ[$];
  logic [7:0] rdExpQ[$];
  string      rdNameQ[$];
  bit         txAbort = 1'b0;

  // Reference model of the receive side and flags
  logic       rxReadyM = 1'b0;
  logic       overrunM = 1'b0;
  logic       framingM = 1'b0;
  logic [7:0] rxBufM = 8'h00;

  function automatic logic [7:0] statusM(input logic holdBusy);
    return {4'b0000, framingM, overrunM, ~holdBusy, rxReadyM};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Read monitor: every strobed read cycle pops one expected value
  always @(negedge clock) begin
    if (readEnable) begin
      if (rdExpQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got %h expected none", readData);
      end else begin
        check8(rdNameQ.pop_front(), readData, rdExpQ.pop_front());
      end
    end
  end

  // TX monitor: decodes 8N1 frames at mid-bit and compares with the queue
  initial begin : txMon
    logic [7:0] got;
    logic [7:0] exp;
    logic       startOk;
    logic       stopBit;
    forever begin
      @(negedge clock);
      if (reset && txd === 1'b0) begin
        txStartQ.push_back(cyc);
        repeat (CPB / 2 - 1) @(negedge clock);
        startOk = (txd === 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clock);
          got[b] = txd;
        end
        repeat (CPB) @(negedge clock);
        stopBit = txd;
        if (txAbort) begin
          txAbort = 1'b0;
        end else begin
          vectors++;
          if (txExpQ.size() == 0) begin
            miscompares++;
            $display("FAIL tx_unexpected: got %h expected none", got);
          end else begin
            exp = txExpQ.pop_front();
            if (got !== exp || !startOk || stopBit !== 1'b1) begin
              miscompares++;
              $display("FAIL tx_frame: got %h start_ok=%b stop=%b expected %h start_ok=1 stop=1",
                       got, startOk, stopBit, exp);
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d, input logic alsoRead);
    addressBus  = a;
    writeData   = d;
    writeEnable = 1'b1;
    readEnable  = alsoRead;
    @(posedge clock);
    #1;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] a, input logic [7:0] exp, input string name);
    rdExpQ.push_back(exp);
    rdNameQ.push_back(name);
    addressBus = a;
    readEnable = 1'b1;
    @(posedge clock);
    #1;
    readEnable = 1'b0;
  endtask

  task automatic readStatus(input string name);
    busRead(ST, statusM(1'b0), name);
  endtask

  task automatic readDataReg(input string name);
    busRead(DT, rxBufM, name);
    rxReadyM = 1'b0;
  endtask

  // Drive one 8N1 frame on rxd and update the model with its delivery
  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      idle(CPB);
    end
    rxd = 1'b1;
    idle(6);
    if (!rxReadyM) begin
      rxBufM   = b;
      rxReadyM = 1'b1;
    end else begin
      overrunM = 1'b1;
    end
    if (!stopBit) framingM = 1'b1;
  endtask

  task automatic waitTxDrain(input string name);
    for (int t = 0; t < 400 && txExpQ.size() != 0; t++) idle(1);
    vectors++;
    if (txExpQ.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d pending frames expected 0", name, txExpQ.size());
    end
  endtask

  initial begin : stim
    logic [15:0] addrs[7];
    logic [7:0]  a5v;
    logic        expTx;
    logic [7:0]  b;
    int          k;
    int          d;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check1("txd_in_reset", txd, 1'b1);
    reset = 1'b1;
    idle(2);
    check1("txd_after_reset", txd, 1'b1);
    busRead(ST, 8'h02, "status_reset");
    busRead(DT, 8'h00, "data_reset");
    addrs = '{16'hF1FF, 16'hF200, 16'hF201, 16'hF202, 16'h0000, 16'h7201, 16'(($urandom & 32'hFFFF))};
    foreach (addrs[i]) begin
      addressBus = addrs[i];
      @(negedge clock);
      check1("selected", selected, (addrs[i] == ST) || (addrs[i] == DT));
      if (!((addrs[i] == ST) || (addrs[i] == DT))) check8("readdata_unselected", readData, 8'h00);
      @(posedge clock);
      #1;
    end

    // Single byte A5 with cycle-exact txd timing
    a5v = 8'hA5;
    txExpQ.push_back(a5v);
    busWrite(DT, a5v, 1'b0);
    addressBus = ST;
    #1;
    check1("hold_busy_after_write", readData[1], 1'b0);
    for (int j = 0; j < 42; j++) begin
      @(negedge clock);
      if (j == 1) check1("hold_free_next_cycle", readData[1], 1'b1);
      k = j - 2;
      if (j < 2)       expTx = 1'b1;
      else if (k < 4)  expTx = 1'b0;
      else if (k < 36) expTx = a5v[(k - 4) / 4];
      else             expTx = 1'b1;
      check1($sformatf("txd_a5_cyc%0d", j), txd, expTx);
    end
    @(posedge clock);
    #1;
    waitTxDrain("tx_a5_drain");
    idle(4);

    // Back-to-back: 55 then 0F on the take edge; FF dropped while both busy
    txStartQ.delete();
    txExpQ.push_back(8'h55);
    txExpQ.push_back(8'h0F);
    busWrite(DT, 8'h55, 1'b0);
    busWrite(DT, 8'h0F, 1'b0);
    idle(1);
    busWrite(DT, 8'hFF, 1'b0);
    busRead(ST, statusM(1'b1), "status_hold_full");
    waitTxDrain("tx_b2b_drain");
    idle(60);
    vectors++;
    if (txStartQ.size() != 2 || (txStartQ[1] - txStartQ[0]) < 10 * CPB
        || (txStartQ[1] - txStartQ[0]) > 10 * CPB + 1) begin
      miscompares++;
      $display("FAIL tx_b2b_spacing: got %0d frames expected 2 contiguous", txStartQ.size());
    end

    // Receive 3C
    sendRx(8'h3C, 1'b1);
    readStatus("status_rx_ready");
    readDataReg("data_rx_3c");
    readStatus("status_rx_consumed");

    // Overrun then framing error, then clear both
    sendRx(8'h11, 1'b1);
    sendRx(8'h22, 1'b1);
    readStatus("status_overrun");
    readDataReg("data_overrun_keeps_first");
    sendRx(8'h33, 1'b0);
    readStatus("status_framing");
    busWrite(ST, 8'h0C, 1'b0);
    overrunM = 1'b0;
    framingM = 1'b0;
    readStatus("status_cleared");
    readDataReg("data_framing_byte");

    // Write and read together: write happens, read leaves rxReady alone
    sendRx(8'h5A, 1'b1);
    rdExpQ.push_back(rxBufM);
    rdNameQ.push_back("data_rw_same_cycle");
    txExpQ.push_back(8'h96);
    busWrite(DT, 8'h96, 1'b1);
    idle(2);
    readStatus("status_after_rw");
    readDataReg("data_after_rw");
    waitTxDrain("tx_rw_drain");

    // One-cycle glitch on rxd delivers nothing
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(20);
    readStatus("status_after_glitch");

    // Reset in the middle of a data bit
    idle(4);
    busWrite(DT, 8'hC3, 1'b0);
    txAbort = 1'b1;
    idle(12);
    #3;
    reset = 1'b0;
    #1;
    check1("txd_async_reset", txd, 1'b1);
    idle(2);
    reset = 1'b1;
    rxReadyM = 1'b0;
    overrunM = 1'b0;
    framingM = 1'b0;
    rxBufM   = 8'h00;
    idle(2);
    busRead(ST, 8'h02, "status_after_mid_reset");
    idle(50);

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: begin
          txExpQ.push_back(b);
          busWrite(DT, b, 1'b0);
          idle(45);
        end
        1: sendRx(b, ($urandom_range(0, 3) != 0));
        2: readDataReg("data_random");
        default: begin
          readStatus("status_random");
          d = $urandom_range(0, 255);
          busWrite(ST, 8'(d), 1'b0);
          if (d[2]) overrunM = 1'b0;
          if (d[3]) framingM = 1'b0;
        end
      endcase
    end
    readStatus("status_final");
    waitTxDrain("tx_final_drain");
    idle(4);
    vectors++;
    if (rdExpQ.size() != 0) begin
      miscompares++;
      $display("FAIL rd_pending: got %0d expected 0", rdExpQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
